soc_nco: RTL and testbench

SOC_NCO -- requirements
Module: soc_nco

---
 rtl/soc_nco.sv | 135 +++++++++++++
 tb/tb_soc_nco.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_nco.sv
// soc_nco: single-voice numerically controlled oscillator.
// A 32-bit phase accumulator advances by inc on each sample tick while the
// gate is high. The accumulated phase is shaped into saw, square, triangle or
// LFSR noise one cycle later, and presented on a valid/ready output with a
// sticky overrun flag.
// Optional build macro SOC_NCO_GLIDE_EN: inc approaches freq_word
// exponentially (portamento) instead of jumping to it on each tick.
module soc_nco #(
  parameter int unsigned GLIDE_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] freq_word,
  input  logic [1:0]  wave_sel,
  input  logic        gate,
  input  logic        sample_tick,
  input  logic        sample_ready,
  input  logic        clr_overrun,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  output logic        overrun
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // A shift wider than the error term would leave glide permanently in snap mode
  if (GLIDE_SHIFT > 32) begin : g_glide_shift_range
    $error("soc_nco: GLIDE_SHIFT must be 0..32");
  end

  logic [31:0] phase;
  logic [31:0] inc;
  logic [31:0] inc_next;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        pending;
  logic [15:0] tri_fold;
  logic [15:0] wave_value;
  logic        ovr_set;

  // Next LFSR state: shift right, fold taps back in when a one falls out
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) begin
      lfsr_next = (lfsr >> 1) ^ LFSR_TAPS;
    end
  end

`ifdef SOC_NCO_GLIDE_EN
  logic signed [32:0] glide_err;
  logic signed [32:0] glide_step;

  // Move inc a 2^-GLIDE_SHIFT fraction of the remaining distance toward
  // freq_word; once the fraction rounds to zero, land exactly on the target
  always_comb begin
    glide_err  = $signed({1'b0, freq_word}) - $signed({1'b0, inc});
    glide_step = glide_err >>> GLIDE_SHIFT;
    if ((glide_step == '0) && (glide_err != '0)) begin
      inc_next = freq_word;
    end else begin
      inc_next = inc + glide_step[31:0];
    end
  end
`else
  // Without glide the new increment is simply the programmed frequency word
  always_comb begin
    inc_next = freq_word;
  end
`endif

  // Shape the current phase (already advanced by the last tick) into a sample
  always_comb begin
    tri_fold = phase[31] ? ~phase[30:15] : phase[30:15];
    case (wave_sel)
      2'b00:   wave_value = phase[31:16] ^ 16'h8000;
      2'b01:   wave_value = phase[31] ? 16'h8000 : 16'h7FFF;
      2'b10:   wave_value = tri_fold ^ 16'h8000;
      default: wave_value = lfsr;
    endcase
  end

  // Overwriting a sample nobody has taken yet is the only overrun source
  always_comb begin
    ovr_set = pending & sample_valid & ~sample_ready;
  end

  // Accumulator stage: phase, increment, noise source and the pending strobe.
  // The phase add uses the increment held before this edge, so a new
  // freq_word is heard from the following tick onwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= '0;
      inc     <= '0;
      lfsr    <= LFSR_SEED;
      pending <= 1'b0;
    end else begin
      pending <= sample_tick;
      if (sample_tick) begin
        inc <= inc_next;
      end
      if (!gate) begin
        phase <= '0;
      end else if (sample_tick) begin
        phase <= phase + inc;
        lfsr  <= lfsr_next;
      end
    end
  end

  // Output stage: load a computed sample, retire it on handshake, track overrun.
  // A load always wins over a retire, so a handshake coinciding with a new
  // sample keeps valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (pending) begin
        sample_data  <= gate ? wave_value : 16'h0000;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soc_nco.sv
// tb_soc_nco: directed bench for soc_nco with a cycle model of the voice and
// a per-cycle comparison of valid, data and overrun against that model.
module tb_soc_nco;

  logic        clk;
  logic        reset_n;
  logic [31:0] freq_word;
  logic [1:0]  wave_sel;
  logic        gate;
  logic        sample_tick;
  logic        sample_ready;
  logic        clr_overrun;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        overrun;

  soc_nco #(.GLIDE_SHIFT(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .freq_word    (freq_word),
    .wave_sel     (wave_sel),
    .gate         (gate),
    .sample_tick  (sample_tick),
    .sample_ready (sample_ready),
    .clr_overrun  (clr_overrun),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] noise_seq [512];
  longint      m_phase;
  longint      m_inc;
  int          m_noise_idx;
  bit          m_pend;
  bit          e_valid;
  logic [15:0] e_data;
  bit          e_ovr;
  bit          m_set;
  longint      m_d;
  longint      m_step;

  // Sample value from the waveform definitions, using plain arithmetic on the phase
  function automatic logic [15:0] wave_of(input logic [1:0] sel, input longint ph, input logic [15:0] noise);
    longint top;
    longint t;
    top = ph / 65536;
    case (sel)
      2'd0: return 16'((top + 32768) % 65536);
      2'd1: return (ph < 64'h8000_0000) ? 16'd32767 : 16'd32768;
      2'd2: begin
        t = (ph / 32768) % 65536;
        if (ph >= 64'h8000_0000) t = 65535 - t;
        return 16'((t + 32768) % 65536);
      end
      default: return noise;
    endcase
  endfunction

  initial begin
    logic [15:0] s;
    noise_seq[0] = 16'hACE1;
    for (int i = 1; i < 512; i++) begin
      s = noise_seq[i-1];
      noise_seq[i] = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_inc = 0; m_noise_idx = 0; m_pend = 0;
      e_valid = 0; e_data = 16'h0000; e_ovr = 0;
    end else begin
      m_set = 0;
      if (m_pend) begin
        m_set   = e_valid && !sample_ready;
        e_data  = gate ? wave_of(wave_sel, m_phase, noise_seq[m_noise_idx]) : 16'h0000;
        e_valid = 1;
      end else if (e_valid && sample_ready) begin
        e_valid = 0;
      end
      if (m_set) e_ovr = 1;
      else if (clr_overrun) e_ovr = 0;
      m_pend = sample_tick;
      if (!gate) m_phase = 0;
      else if (sample_tick) begin
        m_phase = (m_phase + m_inc) % 64'h1_0000_0000;
        m_noise_idx = (m_noise_idx + 1) % 512;
      end
      if (sample_tick) begin
`ifdef SOC_NCO_GLIDE_EN
        m_d    = longint'(freq_word) - m_inc;
        m_step = m_d >>> 8;
        if (m_step == 0 && m_d != 0) m_inc = longint'(freq_word);
        else m_inc = (m_inc + m_step) & 64'hFFFF_FFFF;
`else
        m_inc = longint'(freq_word);
`endif
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_valid", 32'(sample_valid), 32'(e_valid));
      check("cyc_data", 32'(sample_data), 32'(e_data));
      check("cyc_overrun", 32'(overrun), 32'(e_ovr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_cycle(input bit raise_gate);
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    if (raise_gate) gate = 1'b1;
  endtask

  // Called in the cycle after the tick: sample must appear two cycles after the tick
  task automatic expect_sample(input logic [15:0] exp, input string name);
    int lat;
    bit got;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      if (sample_valid) got = 1'b1;
      else lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd2);
    check(name, 32'(sample_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b1;
    freq_word    = 32'h0;
    wave_sel     = 2'b00;
    gate         = 1'b0;
    sample_tick  = 1'b0;
    sample_ready = 1'b1;
    clr_overrun  = 1'b0;
    #2 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("rst_data", 32'(sample_data), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef SOC_NCO_GLIDE_EN
    freq_word = 32'h0100_0000;
    wave_sel  = 2'b00;
    gate      = 1'b1;
    // inc: 0 -> 0x10000 -> 0x1FF00; phase: 0, 0x10000, 0x2FF00
    tick_cycle(0); expect_sample(16'h8000, "glide0");
    tick_cycle(0); expect_sample(16'h8001, "glide1");
    tick_cycle(0); expect_sample(16'h8002, "glide2");
    for (int k = 0; k < 6; k++) begin
      tick_cycle(0);
      expect_sample(wave_of(2'd0, m_phase, 16'h0), "glide_model");
    end
`else
    // Saw at 1/16 of full scale per tick, wrapping on the 17th sample
    freq_word = 32'h1000_0000;
    wave_sel  = 2'b00;
    gate      = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick_cycle(0);
      expect_sample(16'(32'h8000 + k * 32'h1000), $sformatf("saw%0d", k));
    end

    // Gate low mutes; a tick seen with gate low then gate high restarts at phase 0
    gate = 1'b0;
    tick_cycle(0); expect_sample(16'h0000, "gate_low");
    tick_cycle(1); expect_sample(16'h8000, "gate_restart");
    tick_cycle(0); expect_sample(16'h9000, "gate_restart2");

    // Backpressure: two ticks with no consumer
    sample_ready = 1'b0;
    tick_cycle(0);
    tick_cycle(0);
    @(negedge clk);
    @(negedge clk);
    check("bp_data", 32'(sample_data), 32'h0000_B000);
    check("bp_overrun", 32'(overrun), 32'h1);
    check("bp_valid_held", 32'(sample_valid), 32'h1);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_drop", 32'(sample_valid), 32'h0);
    check("bp_overrun_sticky", 32'(overrun), 32'h1);
    @(posedge clk); #1 clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    check("bp_clear", 32'(overrun), 32'h0);

    // Overrun set coinciding with a clear pulse: set wins
    sample_ready = 1'b0;
    tick_cycle(0);
    tick_cycle(0);
    clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    check("set_wins_overrun", 32'(overrun), 32'h1);
    check("set_wins_data", 32'(sample_data), 32'h0000_D000);
    sample_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;

    // Reset mid-run with a sample held and another tick in flight
    sample_ready = 1'b0;
    tick_cycle(0);
    @(posedge clk); #1;
    check("pre_reset_data", 32'(sample_data), 32'h0000_E000);
    tick_cycle(0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(sample_data), 32'h0);
    check("mid_rst_valid", 32'(sample_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    gate         = 1'b0;
    wave_sel     = 2'b11;
    sample_ready = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 32'(sample_valid), 32'h0);
    @(posedge clk); #1;

    // Noise from the seed, then successive LFSR steps
    tick_cycle(1); expect_sample(16'hACE1, "noise0");
    tick_cycle(0); expect_sample(16'hE270, "noise1");
    tick_cycle(0); expect_sample(16'h7138, "noise2");
    tick_cycle(0); expect_sample(noise_seq[3], "noise3");

    // Square at quarter-cycle steps
    freq_word = 32'h4000_0000;
    wave_sel  = 2'b01;
    gate      = 1'b0;
    tick_cycle(0); expect_sample(16'h0000, "sq_muted");
    tick_cycle(1); expect_sample(16'h7FFF, "sq0");
    tick_cycle(0); expect_sample(16'h7FFF, "sq1");
    tick_cycle(0); expect_sample(16'h8000, "sq2");
    tick_cycle(0); expect_sample(16'h8000, "sq3");

    // Triangle at quarter-cycle steps
    wave_sel = 2'b10;
    gate     = 1'b0;
    tick_cycle(0); expect_sample(16'h0000, "tri_muted");
    tick_cycle(1); expect_sample(16'h8000, "tri0");
    tick_cycle(0); expect_sample(16'h0000, "tri1");
    tick_cycle(0); expect_sample(16'h7FFF, "tri2");
    tick_cycle(0); expect_sample(16'hFFFF, "tri3");

    // Frequency change takes effect one tick late, ticks back to back
    wave_sel  = 2'b00;
    freq_word = 32'h0800_0000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 sample_tick = 1'b1;
      if (k == 3) sample_ready = 1'b0;
    end
    @(posedge clk); #1 sample_tick = 1'b0;
    sample_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
